// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of signals between the pipeline datapath/decoder and the stall/flush
// controller.
//   master : pipeline side. Drives hazard information and reads back the
//            per-register enables and bubble requests.
//   slave  : controller side (pipe_hazard_ctrl).
// Hazard inputs : id_valid, id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
//                 ex_is_mul, mem_branch_taken, ext_stall
// Control out   : en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
//                 flush_if_id, flush_id_ex, flush_ex_mem, mul_busy,
//                 stall_cycles[CNT_W-1:0]
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             ex_is_mul;
    logic             mem_branch_taken;
    logic             ext_stall;

    logic             en_pc;
    logic             en_if_id;
    logic             en_id_ex;
    logic             en_ex_mem;
    logic             en_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               ex_is_mul, mem_branch_taken, ext_stall,
        input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, mul_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               ex_is_mul, mem_branch_taken, ext_stall,
        output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, mul_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for a five-stage pipeline. Produces the enable and
// bubble (flush) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Handles load-use stalls, taken-branch squashing and a multi-cycle multiply
// held in EX for MUL_LAT cycles.
// Parameters : MUL_LAT (1..16, 1 = no multiply stall), CNT_W (perf counter)
// Ports      : clk     - rising-edge clock
//              arst_n  - active-low reset, sampled on rising clk
//              hz      - pipe_hazard_ctrl_if.slave (hazard in / control out)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int            CW          = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    // The detect cycle and the release cycle are not counted by cnt, so a
    // multiply occupying EX for MUL_LAT cycles starts the wait at MUL_LAT-2.
    localparam logic [CW-1:0] CNT_START   = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam bit            MUL_STALLS  = (MUL_LAT > 1);

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    // What the controller does this cycle, resolved once in strict priority.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_MUL_START,
        ACT_MUL_HOLD,
        ACT_MUL_RELEASE,
        ACT_LOAD_USE,
        ACT_RUN
    } action_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] stall_q;

    action_t          act;
    logic             lu;
    logic [4:0]       en_v;     // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0]       flush_v;  // {if_id, id_ex, ex_mem}

    assign lu = hz.ex_memread && (hz.ex_rd != 5'd0) && hz.id_valid &&
                ((hz.ex_rd == hz.id_rs1) ||
                 (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    always_comb begin
        // NOTE: every output gets a default before the priority chain, so no
        // path through this block can infer a latch.
        act     = ACT_RUN;
        en_v    = 5'b11111;
        flush_v = 3'b000;

        if (!arst_n)                                            act = ACT_RESET;
        else if (hz.ext_stall)                                  act = ACT_FREEZE;
        else if (hz.mem_branch_taken)                           act = ACT_FLUSH;
        else if (state_q == RUN && hz.ex_is_mul && MUL_STALLS)  act = ACT_MUL_START;
        else if (state_q == MUL_WAIT && cnt_q != '0)            act = ACT_MUL_HOLD;
        else if (state_q == MUL_WAIT)                           act = ACT_MUL_RELEASE;
        else if (lu)                                            act = ACT_LOAD_USE;

        case (act)
            ACT_RESET, ACT_FREEZE: en_v = 5'b00000;
            ACT_FLUSH:             flush_v = 3'b111;
            // Front end and EX freeze; a bubble is pushed into EX/MEM so MEM
            // and WB keep draining older instructions.
            ACT_MUL_START, ACT_MUL_HOLD: begin
                en_v    = 5'b00011;
                flush_v = 3'b001;
            end
            // Load stays in EX->MEM; the consumer waits in ID behind a bubble.
            ACT_LOAD_USE: begin
                en_v    = 5'b00111;
                flush_v = 3'b010;
            end
            default: ;
        endcase
    end

    assign hz.en_pc        = en_v[4];
    assign hz.en_if_id     = en_v[3];
    assign hz.en_id_ex     = en_v[2];
    assign hz.en_ex_mem    = en_v[1];
    assign hz.en_mem_wb    = en_v[0];
    assign hz.flush_if_id  = flush_v[2];
    assign hz.flush_id_ex  = flush_v[1];
    assign hz.flush_ex_mem = flush_v[0];
    assign hz.mul_busy     = (state_q == MUL_WAIT);
    assign hz.stall_cycles = stall_q;

    // NOTE: all state uses non-blocking assignments; reset is synchronous,
    // so it is just the highest-priority action inside the clocked block.
    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET: begin
                state_q <= RUN;
                cnt_q   <= '0;
                stall_q <= '0;
            end
            ACT_FREEZE: ;  // frozen cycles are neither advanced nor counted
            default: begin
                if (!en_v[4] && stall_q != '1) begin
                    stall_q <= stall_q + 1'b1;
                end
                case (act)
                    ACT_FLUSH:       state_q <= RUN;
                    ACT_MUL_START: begin
                        state_q <= MUL_WAIT;
                        cnt_q   <= CNT_START;
                    end
                    ACT_MUL_HOLD:    cnt_q   <= cnt_q - 1'b1;
                    ACT_MUL_RELEASE: state_q <= RUN;
                    default: ;
                endcase
            end
        endcase
    end
endmodule
